// File: rtl/sev_seg_scan_ctrl_if.sv
// Load channel between the ticket/counter logic and the 7-segment scan controller.
// The master offers a new display value; the slave accepts it when it has room.
interface sev_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic                    blank_lz;

    modport master (
        output load_valid,
        output load_data,
        output blank_lz,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  blank_lz,
        output load_ready
    );
endinterface

// File: rtl/sev_seg_scan_ctrl.sv
// Scans NUM_DIGITS BCD digits through one shared segment decoder onto a common-anode display.
// New values are held in a pending buffer and committed only at frame boundaries.
module sev_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sev_seg_scan_ctrl_if.slave    load_if,
    output logic [3:0]            dec_num,
    input  logic [6:0]            dec_seg,
    output logic [6:0]            seg_n,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  frame_done
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int DATA_W = 4 * NUM_DIGITS;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        slot_cnt_r;
    logic [CNT_W-1:0]        slot_cnt_nxt_s;
    logic [IDX_W-1:0]        digit_idx_r;
    logic [IDX_W-1:0]        digit_idx_nxt_s;
    logic                    slot_end_s;
    logic                    frame_end_s;

    logic [DATA_W-1:0]       disp_r;
    logic [DATA_W-1:0]       pend_r;
    logic                    pend_full_r;
    logic [6:0]              seg_n_r;

    logic [3:0]              digit_raw_s;
    logic                    digit_bad_s;
    logic                    upper_zero_s;
    logic                    suppress_s;
    logic [3:0]              dec_num_s;
    logic [NUM_DIGITS-1:0]   an_n_s;

    // Slot/digit sequencing and the BLANK/SHOW decision for the next cycle
    always_comb begin
        slot_end_s      = (slot_cnt_r == LAST_CNT);
        frame_end_s     = slot_end_s && (digit_idx_r == LAST_IDX);
        slot_cnt_nxt_s  = slot_cnt_r + CNT_ONE;
        digit_idx_nxt_s = digit_idx_r;
        state_nxt_s     = ST_SHOW;
        if (slot_end_s) begin
            slot_cnt_nxt_s = {CNT_W{1'b0}};
            if (digit_idx_r == LAST_IDX) begin
                digit_idx_nxt_s = {IDX_W{1'b0}};
            end else begin
                digit_idx_nxt_s = digit_idx_r + IDX_ONE;
            end
        end else begin
            slot_cnt_nxt_s = slot_cnt_r + CNT_ONE;
        end
        if (slot_cnt_nxt_s < BLANK_LIM) begin
            state_nxt_s = ST_BLANK;
        end else begin
            state_nxt_s = ST_SHOW;
        end
    end

    // Scan state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_BLANK;
            slot_cnt_r  <= {CNT_W{1'b0}};
            digit_idx_r <= {IDX_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            slot_cnt_r  <= slot_cnt_nxt_s;
            digit_idx_r <= digit_idx_nxt_s;
        end
    end

    // Current digit, its decoder code and whether its anode stays dark
    always_comb begin
        digit_raw_s  = disp_r[{digit_idx_r, 2'b00} +: 4];
        digit_bad_s  = (digit_raw_s > 4'd9);
        // A leading zero is one where this digit and every digit above it are zero
        upper_zero_s = ((disp_r >> {digit_idx_r, 2'b00}) == {DATA_W{1'b0}});
        suppress_s   = digit_bad_s ||
                       (load_if.blank_lz && (digit_idx_r != {IDX_W{1'b0}}) && upper_zero_s);
        if (digit_bad_s) begin
            dec_num_s = 4'h0;
        end else begin
            dec_num_s = digit_raw_s;
        end
        an_n_s = {NUM_DIGITS{1'b1}};
        case (state_r)
            ST_SHOW: begin
                if (suppress_s) begin
                    an_n_s = {NUM_DIGITS{1'b1}};
                end else begin
                    an_n_s = ~(AN_ONE << digit_idx_r);
                end
            end
            default: an_n_s = {NUM_DIGITS{1'b1}};
        endcase
    end

    // Segment output register; dark during the anti-ghosting window
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_n_r <= 7'h7F;
        end else if (state_r == ST_BLANK) begin
            seg_n_r <= 7'h7F;
        end else begin
            seg_n_r <= dec_seg;
        end
    end

    // Pending buffer and frame-aligned commit into the displayed value
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r      <= {DATA_W{1'b0}};
            pend_full_r <= 1'b0;
            disp_r      <= {DATA_W{1'b0}};
        end else if (frame_end_s && pend_full_r) begin
            disp_r      <= pend_r;
            pend_full_r <= 1'b0;
        end else if (load_if.load_valid && !pend_full_r) begin
            pend_r      <= load_if.load_data;
            pend_full_r <= 1'b1;
        end else begin
            pend_full_r <= pend_full_r;
        end
    end

    assign load_if.load_ready = ~pend_full_r;
    assign dec_num            = dec_num_s;
    assign an_n               = an_n_s;
    assign seg_n              = seg_n_r;
    assign frame_done         = frame_end_s;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Directed bench for sev_seg_scan_ctrl with 4 digits, 8-cycle slots and 2 blank cycles.
// A behavioural segment decoder closes the dec_num -> dec_seg loop.
module tb_sev_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dec_num;
    logic [6:0] dec_seg;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sev_seg_scan_ctrl_if #(.NUM_DIGITS(4)) lif ();

    sev_seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_if    (lif),
        .dec_num    (dec_num),
        .dec_seg    (dec_seg),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    always_comb dec_seg = seg_code(dec_num);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        check("ld_ready", 32'(lif.load_ready), 32'd1);
        lif.load_valid = 1'b1;
        lif.load_data  = v;
        step();
        lif.load_valid = 1'b0;
        check("ld_busy", 32'(lif.load_ready), 32'd0);
    endtask

    // Steps until frame_done is seen (bounded), then one more cycle to the frame start.
    task automatic wait_frame();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("fd_seen", 32'(frame_done), 32'd1);
        step();
    endtask

    // Checks a whole frame starting at slot 0 of digit 0.
    task automatic check_frame(input logic [15:0] val, input logic [3:0] lit);
        int         d;
        int         s;
        logic [3:0] dig;
        logic [3:0] exp_dec;
        logic [3:0] exp_an;
        for (int c = 0; c < 32; c++) begin
            d       = c / 8;
            s       = c % 8;
            dig     = val[d*4 +: 4];
            exp_dec = (dig > 4'd9) ? 4'h0 : dig;
            check("dec_num", 32'(dec_num), 32'(exp_dec));
            if (s == 1) begin
                check("an_blank", 32'(an_n), 32'hF);
            end
            if (s == 2) begin
                check("seg_blank", 32'(seg_n), 32'h7F);
            end
            if (s == 4) begin
                exp_an = lit[d] ? ~(4'b0001 << d) : 4'hF;
                check("an_show", 32'(an_n), 32'(exp_an));
                check("seg_show", 32'(seg_n), 32'(seg_code(exp_dec)));
            end
            if (s == 7) begin
                check("frame_done", 32'(frame_done), (d == 3) ? 32'd1 : 32'd0);
            end
            step();
        end
    endtask

    initial begin
        int         d;
        int         s;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic [15:0] old_val;

        rst            = 1'b1;
        lif.load_valid = 1'b0;
        lif.load_data  = 16'h0000;
        lif.blank_lz   = 1'b0;

        // 1. reset and first slots
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_an", 32'(an_n), 32'hF);
            check("rst_seg", 32'(seg_n), 32'h7F);
            check("rst_fd", 32'(frame_done), 32'd0);
            check("rst_ready", 32'(lif.load_ready), 32'd1);
        end
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            s       = i % 8;
            d       = i / 8;
            exp_an  = (s < 2) ? 4'hF : ~(4'b0001 << d);
            exp_seg = (i == 0 || s == 1 || s == 2) ? 7'h7F : 7'h40;
            check("start_an", 32'(an_n), 32'(exp_an));
            check("start_seg", 32'(seg_n), 32'(exp_seg));
            check("start_dec", 32'(dec_num), 32'h0);
            step();
        end
        wait_frame();

        // 2. load 1234
        do_load(16'h1234);
        wait_frame();
        check("commit_ready", 32'(lif.load_ready), 32'd1);
        check_frame(16'h1234, 4'hF);

        // 3. load 5678 mid-frame; old value stays until the frame ends
        old_val = 16'h1234;
        for (int i = 0; i < 10; i++) step();
        do_load(16'h5678);
        for (int c = 11; c < 32; c++) begin
            d = c / 8;
            check("old_dec", 32'(dec_num), 32'(old_val[d*4 +: 4]));
            check("old_ready", 32'(lif.load_ready), 32'd0);
            check("old_fd", 32'(frame_done), (c == 31) ? 32'd1 : 32'd0);
            step();
        end
        check("new_ready", 32'(lif.load_ready), 32'd1);
        check_frame(16'h5678, 4'hF);

        // 4. leading-zero blanking
        do_load(16'h0070);
        wait_frame();
        lif.blank_lz = 1'b1;
        check_frame(16'h0070, 4'b0011);
        lif.blank_lz = 1'b0;
        check_frame(16'h0070, 4'hF);

        // 5. non-BCD digit
        do_load(16'h0A00);
        wait_frame();
        check_frame(16'h0A00, 4'b1011);

        // load on the frame_done cycle commits one frame later
        for (int i = 0; i < 31; i++) step();
        check("edge_fd", 32'(frame_done), 32'd1);
        do_load(16'h4321);
        check_frame(16'h0A00, 4'b1011);
        check("edge_ready", 32'(lif.load_ready), 32'd1);
        check_frame(16'h4321, 4'hF);

        // 6. second offer held off, then reset drops pending and display
        do_load(16'h9999);
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            check("hold_ready", 32'(lif.load_ready), 32'd0);
            step();
        end
        lif.load_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_ready", 32'(lif.load_ready), 32'd1);
        check("rst2_dec", 32'(dec_num), 32'h0);
        check("rst2_an", 32'(an_n), 32'hF);
        wait_frame();
        check_frame(16'h0000, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
